// File: rtl/eth_udp_pkg.sv
// Shared definitions for the UDP receive demux: header layout, FSM states,
// saturating counter helper and header field extraction.
package eth_udp_pkg;

  localparam int UDP_HDR_BYTES = 8;
  localparam int PORT_W        = 16;

  // Byte offsets of the big-endian header fields within the 8-byte header
  localparam int SRC_OFS = 0;
  localparam int DST_OFS = 2;
  localparam int LEN_OFS = 4;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} udp_state_e;

  // Increment v unless it already holds the all-ones value of a w-bit counter
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] top;
    top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= top) ? v : v + 32'd1;
  endfunction

  // Header byte k sits at hdr[8k+7:8k]; fields are sent most significant byte first
  function automatic logic [PORT_W-1:0] hdr_field(input logic [63:0] hdr, input int ofs);
    return {hdr[ofs*8 +: 8], hdr[(ofs+1)*8 +: 8]};
  endfunction

endpackage

// File: rtl/udp_port_match.sv
// Combinational priority lookup of a UDP port in a packed port table.
// The lowest matching index wins.
module udp_port_match
  import eth_udp_pkg::*;
#(
  parameter int                       PORT_N = 4,
  parameter int                       CH_W   = 2,
  parameter logic [PORT_N*PORT_W-1:0] TABLE  = {16'd18073, 16'd18072, 16'd18071, 16'd18070}
) (
  input  logic [PORT_W-1:0] port,
  output logic              hit,
  output logic [CH_W-1:0]   idx
);

  // Scan from the top so the lowest matching entry is the last one written
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = PORT_N - 1; i >= 0; i--) begin
      if (TABLE[i*PORT_W +: PORT_W] == port) begin
        hit = 1'b1;
        idx = CH_W'(i);
      end
    end
  end

endmodule

// File: rtl/eth_rx_udp_demux.sv
// UDP receive demux: parses the 8-byte UDP header, steers the payload to one
// of PORT_N channels by destination port, checks the UDP length against the
// received byte count and keeps saturating drop/error counters.
module eth_rx_udp_demux
  import eth_udp_pkg::*;
#(
  parameter  int                    DATA_W    = 16,
  localparam int                    KEEP_W    = DATA_W / 8,
  parameter  int                    LEN_W     = $clog2(DATA_W / 8 + 1),
  parameter  int                    PORT_N    = 4,
  localparam int                    CH_W      = (PORT_N > 1) ? $clog2(PORT_N) : 1,
  parameter  logic [PORT_N*16-1:0]  DST_PORTS = {16'd18073, 16'd18072, 16'd18071, 16'd18070},
  parameter  bit                    MATCH_SRC = 1'b0,
  parameter  logic [15:0]           SRC_PORT  = 16'd18070,
  parameter  int                    CNT_W     = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cancel_i,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              ip_cs_err_i,
  output logic [PORT_N-1:0] app_valid_o,
  output logic              app_start_o,
  output logic              app_last_o,
  output logic [PORT_N-1:0] app_cancel_o,
  output logic [DATA_W-1:0] app_data_o,
  output logic [LEN_W-1:0]  app_len_o,
  output logic [CH_W-1:0]   app_ch_o,
  output logic [CNT_W-1:0]  drop_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int HDR_BEATS = 64 / DATA_W;
  localparam int HB_W      = (HDR_BEATS > 1) ? $clog2(HDR_BEATS) : 1;

  udp_state_e         state, state_n;
  logic [63:0]        hdr, hdr_n, hdr_cur;
  logic [HB_W-1:0]    cnt, cnt_n, beat_idx;
  logic [CH_W-1:0]    ch, ch_n;
  logic [15:0]        ulen, ulen_n, bytes, bytes_n, beat_bytes, bytes_tot;
  logic               first, first_n;
  logic               hdr_phase, hdr_done, len_ok, match;
  logic [15:0]        src, dst;
  logic               dst_hit;
  logic [CH_W-1:0]    dst_idx;
  logic [PORT_N-1:0]  ch_hot;
  logic [CNT_W-1:0]   drop_n, err_n;
  logic [PORT_N-1:0]  valid_n, cancel_n;
  logic               start_n, last_n;
  logic [DATA_W-1:0]  data_n;
  logic [LEN_W-1:0]   len_n;
  logic [CH_W-1:0]    ch_out_n;

  // Header assembly: merge the current beat into the bytes captured so far
  always_comb begin
    hdr_phase = valid_i && (start_i || state == HDR);
    beat_idx  = start_i ? '0 : cnt;
    hdr_done  = hdr_phase && (beat_idx == HB_W'(HDR_BEATS - 1));
    hdr_cur   = hdr;
    for (int b = 0; b < HDR_BEATS; b++) begin
      if (hdr_phase && beat_idx == HB_W'(b)) hdr_cur[b*DATA_W +: DATA_W] = data_i;
    end
  end

  assign src    = hdr_field(hdr_cur, SRC_OFS);
  assign dst    = hdr_field(hdr_cur, DST_OFS);
  assign match  = dst_hit && (!MATCH_SRC || src == SRC_PORT);
  assign ch_hot = PORT_N'(1) << ch;

  udp_port_match #(
    .PORT_N (PORT_N),
    .CH_W   (CH_W),
    .TABLE  (DST_PORTS)
  ) u_match (
    .port (dst),
    .hit  (dst_hit),
    .idx  (dst_idx)
  );

  // Payload byte accounting for the length check on the final beat
  assign beat_bytes = last_i ? 16'(len_i) : 16'(KEEP_W);
  assign bytes_tot  = bytes + beat_bytes;
  assign len_ok     = (ulen >= 16'(UDP_HDR_BYTES)) && (bytes_tot == ulen - 16'(UDP_HDR_BYTES));

  // Next-state, counter and output-beat decode
  always_comb begin
    state_n  = state;
    hdr_n    = hdr;
    cnt_n    = cnt;
    ch_n     = ch;
    ulen_n   = ulen;
    bytes_n  = bytes;
    first_n  = first;
    drop_n   = drop_cnt_o;
    err_n    = err_cnt_o;
    valid_n  = '0;
    cancel_n = '0;
    start_n  = 1'b0;
    last_n   = 1'b0;
    data_n   = '0;
    len_n    = '0;
    ch_out_n = app_ch_o;
    if (cancel_i) begin
      // Frame abort from the MAC wins over any beat presented this cycle
      if (state == PAYLOAD) begin
        cancel_n = ch_hot;
        ch_out_n = ch;
      end
      state_n = IDLE;
    end else if (valid_i) begin
      if (start_i && state == PAYLOAD) begin
        cancel_n = ch_hot;
        ch_out_n = ch;
      end
      if (hdr_phase) begin
        if (ip_cs_err_i) begin
          err_n   = CNT_W'(sat_inc(32'(err_cnt_o), CNT_W));
          state_n = IDLE;
        end else begin
          hdr_n = hdr_cur;
          cnt_n = beat_idx + HB_W'(1);
          if (hdr_done) begin
            ulen_n  = hdr_field(hdr_cur, LEN_OFS);
            bytes_n = '0;
            first_n = 1'b1;
            if (!match) begin
              drop_n  = CNT_W'(sat_inc(32'(drop_cnt_o), CNT_W));
              state_n = last_i ? IDLE : DROP;
            end else begin
              ch_n    = dst_idx;
              state_n = last_i ? IDLE : PAYLOAD;
            end
          end else begin
            state_n = last_i ? IDLE : HDR;
          end
        end
      end else begin
        case (state)
          PAYLOAD: begin
            if (ip_cs_err_i || (last_i && !len_ok)) begin
              cancel_n = ch_hot;
              ch_out_n = ch;
              err_n    = CNT_W'(sat_inc(32'(err_cnt_o), CNT_W));
              state_n  = IDLE;
            end else begin
              valid_n  = ch_hot;
              start_n  = first;
              last_n   = last_i;
              data_n   = data_i;
              len_n    = last_i ? len_i : LEN_W'(KEEP_W);
              ch_out_n = ch;
              first_n  = 1'b0;
              bytes_n  = bytes_tot;
              if (last_i) state_n = IDLE;
            end
          end
          DROP:    if (last_i) state_n = IDLE;
          default: ;
        endcase
      end
    end
  end

  // State, header capture, counters and registered output beat
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      hdr          <= '0;
      cnt          <= '0;
      ch           <= '0;
      ulen         <= '0;
      bytes        <= '0;
      first        <= 1'b0;
      drop_cnt_o   <= '0;
      err_cnt_o    <= '0;
      app_valid_o  <= '0;
      app_cancel_o <= '0;
      app_start_o  <= 1'b0;
      app_last_o   <= 1'b0;
      app_data_o   <= '0;
      app_len_o    <= '0;
      app_ch_o     <= '0;
    end else begin
      state        <= state_n;
      hdr          <= hdr_n;
      cnt          <= cnt_n;
      ch           <= ch_n;
      ulen         <= ulen_n;
      bytes        <= bytes_n;
      first        <= first_n;
      drop_cnt_o   <= drop_n;
      err_cnt_o    <= err_n;
      app_valid_o  <= valid_n;
      app_cancel_o <= cancel_n;
      app_start_o  <= start_n;
      app_last_o   <= last_n;
      app_data_o   <= data_n;
      app_len_o    <= len_n;
      app_ch_o     <= ch_out_n;
    end
  end

endmodule

// File: tb/tb_eth_rx_udp_demux.sv
// Directed bench for eth_rx_udp_demux: a 16-bit instance driven from a vector
// table, plus hand sequences for async reset and a 64-bit source-matching
// instance with counter saturation.
module tb_eth_rx_udp_demux;

  localparam logic       Z = 1'b0;
  localparam logic       O = 1'b1;
  localparam logic [1:0] K = 2'd2;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        a_cancel, a_valid, a_start, a_last, a_err;
  logic [15:0] a_data;
  logic [1:0]  a_len;
  logic [3:0]  a_vo, a_co;
  logic        a_so, a_lo;
  logic [15:0] a_do;
  logic [1:0]  a_no, a_cho;
  logic [15:0] a_drop, a_errc;

  // 64-bit instance, source port checked
  logic        b_cancel, b_valid, b_start, b_last, b_err;
  logic [63:0] b_data;
  logic [3:0]  b_len;
  logic [3:0]  b_vo, b_co;
  logic        b_so, b_lo;
  logic [63:0] b_do;
  logic [3:0]  b_no;
  logic [1:0]  b_cho;
  logic [15:0] b_drop, b_errc;

  eth_rx_udp_demux dut16 (
    .clk(clk), .nreset(nreset), .cancel_i(a_cancel), .valid_i(a_valid),
    .start_i(a_start), .last_i(a_last), .data_i(a_data), .len_i(a_len),
    .ip_cs_err_i(a_err), .app_valid_o(a_vo), .app_start_o(a_so),
    .app_last_o(a_lo), .app_cancel_o(a_co), .app_data_o(a_do),
    .app_len_o(a_no), .app_ch_o(a_cho), .drop_cnt_o(a_drop), .err_cnt_o(a_errc)
  );

  eth_rx_udp_demux #(.DATA_W(64), .MATCH_SRC(1'b1)) dut64 (
    .clk(clk), .nreset(nreset), .cancel_i(b_cancel), .valid_i(b_valid),
    .start_i(b_start), .last_i(b_last), .data_i(b_data), .len_i(b_len),
    .ip_cs_err_i(b_err), .app_valid_o(b_vo), .app_start_o(b_so),
    .app_last_o(b_lo), .app_cancel_o(b_co), .app_data_o(b_do),
    .app_len_o(b_no), .app_ch_o(b_cho), .drop_cnt_o(b_drop), .err_cnt_o(b_errc)
  );

  typedef struct {
    logic        c, v, s, l, e;
    logic [15:0] d;
    logic [1:0]  n;
    logic [3:0]  ev, ec;
    logic        es, el;
    logic [15:0] ed;
    logic [1:0]  en, ech;
    logic [15:0] dr, er;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic logic [15:0] sw(input logic [15:0] p);
    return {p[7:0], p[15:8]};
  endfunction

  function automatic logic [63:0] bh(input logic [15:0] s, input logic [15:0] d, input logic [15:0] u);
    return {16'h0000, sw(u), sw(d), sw(s)};
  endfunction

  // Row with no delivered payload beat; ec is the expected cancel vector
  task automatic nx(input logic c, input logic v, input logic s, input logic l,
                    input logic [15:0] d, input logic e, input logic [3:0] ec,
                    input logic [15:0] dr, input logic [15:0] er);
    vec_t t;
    t.c = c; t.v = v; t.s = s; t.l = l; t.e = e; t.d = d; t.n = K;
    t.ev = 4'b0; t.ec = ec; t.es = Z; t.el = Z; t.ed = 16'h0; t.en = 2'd0; t.ech = 2'd0;
    t.dr = dr; t.er = er;
    vq.push_back(t);
  endtask

  // Payload beat expected to be delivered unchanged on channel ech
  task automatic pay(input logic l, input logic [15:0] d, input logic [3:0] ev,
                     input logic [1:0] ech, input logic es,
                     input logic [15:0] dr, input logic [15:0] er);
    vec_t t;
    t.c = Z; t.v = O; t.s = Z; t.l = l; t.e = Z; t.d = d; t.n = K;
    t.ev = ev; t.ec = 4'b0; t.es = es; t.el = l; t.ed = d; t.en = K; t.ech = ech;
    t.dr = dr; t.er = er;
    vq.push_back(t);
  endtask

  // Four 16-bit header beats; the drop counter reads dr1 after the last one
  task automatic hdr4(input logic [15:0] s, input logic [15:0] d, input logic [15:0] u,
                      input logic [15:0] dr0, input logic [15:0] dr1, input logic [15:0] er);
    nx(Z, O, O, Z, sw(s), Z, 4'b0, dr0, er);
    nx(Z, O, Z, Z, sw(d), Z, 4'b0, dr0, er);
    nx(Z, O, Z, Z, sw(u), Z, 4'b0, dr0, er);
    nx(Z, O, Z, Z, 16'h0000, Z, 4'b0, dr1, er);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic a_beat(input logic c, input logic v, input logic s, input logic l,
                        input logic [15:0] d, input logic e);
    a_cancel = c; a_valid = v; a_start = s; a_last = l; a_data = d; a_len = K; a_err = e;
    @(posedge clk); #1;
  endtask

  task automatic b_beat(input logic s, input logic l, input logic [63:0] d);
    b_cancel = Z; b_valid = O; b_start = s; b_last = l; b_data = d; b_len = 4'd8; b_err = Z;
    @(posedge clk); #1;
  endtask

  initial begin
    // Directed vector table for the 16-bit instance
    // Delivery on ch 2 with a bubble mid-payload
    hdr4(16'd18070, 16'd18072, 16'd12, 16'd0, 16'd0, 16'd0);
    pay(Z, 16'hA1B2, 4'b0100, 2'd2, O, 16'd0, 16'd0);
    nx(Z, Z, Z, Z, 16'h0, Z, 4'b0, 16'd0, 16'd0);
    pay(O, 16'hC3D4, 4'b0100, 2'd2, Z, 16'd0, 16'd0);
    nx(Z, Z, Z, Z, 16'h0, Z, 4'b0, 16'd0, 16'd0);
    // Unknown port dropped, then a delivery on ch 0
    hdr4(16'd18070, 16'd9999, 16'd12, 16'd0, 16'd1, 16'd0);
    nx(Z, O, Z, O, 16'h5555, Z, 4'b0, 16'd1, 16'd0);
    hdr4(16'd18070, 16'd18070, 16'd10, 16'd1, 16'd1, 16'd0);
    pay(O, 16'h0A0B, 4'b0001, 2'd0, O, 16'd1, 16'd0);
    // Length field 20 with only 4 payload bytes
    hdr4(16'd18070, 16'd18070, 16'd20, 16'd1, 16'd1, 16'd0);
    pay(Z, 16'h1111, 4'b0001, 2'd0, O, 16'd1, 16'd0);
    nx(Z, O, Z, O, 16'h2222, Z, 4'b0001, 16'd1, 16'd1);
    // MAC cancel on the 2nd payload beat of ch 1, then a stray beat is ignored
    hdr4(16'd18070, 16'd18071, 16'd14, 16'd1, 16'd1, 16'd1);
    pay(Z, 16'h3333, 4'b0010, 2'd1, O, 16'd1, 16'd1);
    nx(O, O, Z, Z, 16'h4444, Z, 4'b0010, 16'd1, 16'd1);
    nx(Z, O, Z, Z, 16'h5555, Z, 4'b0, 16'd1, 16'd1);
    // New start mid-payload on ch 3, new datagram delivered on ch 2
    hdr4(16'd18070, 16'd18073, 16'd12, 16'd1, 16'd1, 16'd1);
    pay(Z, 16'h6666, 4'b1000, 2'd3, O, 16'd1, 16'd1);
    nx(Z, O, O, Z, sw(16'd18070), Z, 4'b1000, 16'd1, 16'd1);
    nx(Z, O, Z, Z, sw(16'd18072), Z, 4'b0, 16'd1, 16'd1);
    nx(Z, O, Z, Z, sw(16'd10), Z, 4'b0, 16'd1, 16'd1);
    nx(Z, O, Z, Z, 16'h0000, Z, 4'b0, 16'd1, 16'd1);
    pay(O, 16'h7777, 4'b0100, 2'd2, O, 16'd1, 16'd1);
    // IPv4 checksum error during the header
    nx(Z, O, O, Z, sw(16'd18070), Z, 4'b0, 16'd1, 16'd1);
    nx(Z, O, Z, Z, sw(16'd18071), O, 4'b0, 16'd1, 16'd2);
    nx(Z, O, Z, Z, sw(16'd12), Z, 4'b0, 16'd1, 16'd2);
    // Short datagram ending inside the header
    nx(Z, O, O, Z, sw(16'd18070), Z, 4'b0, 16'd1, 16'd2);
    nx(Z, O, Z, O, sw(16'd18071), Z, 4'b0, 16'd1, 16'd2);
    nx(Z, O, Z, Z, sw(16'd12), Z, 4'b0, 16'd1, 16'd2);
    // IPv4 checksum error during the payload of ch 2
    hdr4(16'd18070, 16'd18072, 16'd12, 16'd1, 16'd1, 16'd2);
    pay(Z, 16'h8888, 4'b0100, 2'd2, O, 16'd1, 16'd2);
    nx(Z, O, Z, Z, 16'h9999, O, 4'b0100, 16'd1, 16'd3);

    a_cancel = Z; a_valid = Z; a_start = Z; a_last = Z; a_data = 16'h0; a_len = K; a_err = Z;
    b_cancel = Z; b_valid = Z; b_start = Z; b_last = Z; b_data = 64'h0; b_len = 4'd8; b_err = Z;

    repeat (3) @(posedge clk);
    #1;
    chk("reset16", {a_vo, a_co, a_so, a_lo, a_do, a_no, a_cho, a_drop, a_errc}, 64'h0);
    chk("reset64_out", {b_vo, b_co, b_so, b_lo, b_no, b_cho, b_drop, b_errc}, 64'h0);
    chk("reset64_data", b_do, 64'h0);
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vq.size(); i++) begin
      logic        fw;
      logic [63:0] act, exp;
      a_cancel = vq[i].c; a_valid = vq[i].v; a_start = vq[i].s; a_last = vq[i].l;
      a_data = vq[i].d; a_len = vq[i].n; a_err = vq[i].e;
      @(posedge clk); #1;
      fw  = (vq[i].ev != 4'b0);
      act = {2'b0, a_vo, a_co, a_drop, a_errc,
             fw ? {a_so, a_lo, a_do, a_no, a_cho} : 22'h0};
      exp = {2'b0, vq[i].ev, vq[i].ec, vq[i].dr, vq[i].er,
             fw ? {vq[i].es, vq[i].el, vq[i].ed, vq[i].en, vq[i].ech} : 22'h0};
      chk($sformatf("row%0d", i), act, exp);
    end

    // Async reset mid-payload clears outputs and counters without a clock edge
    a_beat(Z, O, O, Z, sw(16'd18070), Z);
    a_beat(Z, O, Z, Z, sw(16'd18071), Z);
    a_beat(Z, O, Z, Z, sw(16'd12), Z);
    a_beat(Z, O, Z, Z, 16'h0000, Z);
    a_beat(Z, O, Z, Z, 16'hBEEF, Z);
    chk("pre_reset_valid", {a_vo, a_cho, a_do}, {4'b0010, 2'd1, 16'hBEEF});
    #2 nreset = 1'b0;
    #1;
    chk("async_reset", {a_vo, a_co, a_so, a_lo, a_do, a_no, a_cho, a_drop, a_errc}, 64'h0);
    @(negedge clk);
    nreset = 1'b1;
    a_beat(Z, O, Z, O, 16'hCAFE, Z);
    chk("after_reset_idle", {a_vo, a_co}, 8'h0);
    a_beat(Z, Z, Z, Z, 16'h0, Z);

    // 64-bit instance with source-port matching
    b_beat(O, Z, bh(16'd18070, 16'd18071, 16'd16));
    chk("b_hdr_quiet", {b_vo, b_co}, 8'h0);
    b_beat(Z, O, 64'h1122_3344_5566_7788);
    chk("b_deliver", {b_vo, b_so, b_lo, b_no, b_cho}, {4'b0010, O, O, 4'd8, 2'd1});
    chk("b_deliver_data", b_do, 64'h1122_3344_5566_7788);
    b_beat(O, Z, bh(16'd1234, 16'd18071, 16'd16));
    chk("b_wrong_src", {b_vo, b_drop}, {4'b0, 16'd1});
    b_beat(Z, O, 64'h0);
    chk("b_drop_tail", {b_vo, b_co, b_drop}, {8'h0, 16'd1});
    b_beat(O, Z, bh(16'd18070, 16'd18070, 16'd4));
    b_beat(Z, O, 64'h0);
    chk("b_len_lt8", {b_vo, b_co, b_errc}, {4'b0, 4'b0001, 16'd1});
    b_valid = Z;
    @(posedge clk); #1;
    for (int i = 0; i < 65534; i++) begin
      b_beat(O, Z, bh(16'd1234, 16'd18071, 16'd16));
    end
    chk("b_drop_sat", b_drop, 64'hFFFF);
    for (int i = 0; i < 3; i++) begin
      b_beat(O, Z, bh(16'd1234, 16'd18071, 16'd16));
    end
    chk("b_drop_held", b_drop, 64'hFFFF);
    chk("b_err_held", b_errc, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
